// File: rtl/stack_reader_if.sv
// stack_reader_if: push/drain control and LIFO output stream bundle for stack_reader
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
interface stack_reader_if #(parameter int MAX_CAP = 8) ();
  localparam int CW = $clog2(MAX_CAP) + 1;
  logic push_valid;
  logic [`DATA_WIDTH-1:0] push_data;
  logic drain;
  logic out_ready;
  logic out_valid;
  logic [`DATA_WIDTH-1:0] out_data;
  logic out_last;
  logic full;
  logic empty;
  logic [CW-1:0] count;
  logic dropped;
  modport master (
    output push_valid, push_data, drain, out_ready,
    input out_valid, out_data, out_last, full, empty, count, dropped
  );
  modport slave (
    input push_valid, push_data, drain, out_ready,
    output out_valid, out_data, out_last, full, empty, count, dropped
  );
endinterface

// File: rtl/stack_reader.sv
// stack_reader: fill a bounded stack, then stream it out top-first on a drain request
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
module stack_reader #(parameter int MAX_CAP = 8) (
  input logic clock,
  input logic reset,
  stack_reader_if.slave bus
);
  localparam int AW = $clog2(MAX_CAP);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] CAP = CW'(MAX_CAP);
  typedef enum logic {FILL, DRAIN} state_t;
  state_t state, state_nx;
  logic [CW-1:0] count, count_nx, top;
  logic dropped, dropped_nx, push_ok, pop, full;
  logic [`DATA_WIDTH-1:0] mem [MAX_CAP];
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= FILL;
      count <= '0;
      dropped <= 1'b0;
    end else begin
      state <= state_nx;
      count <= count_nx;
      dropped <= dropped_nx;
    end
    if (push_ok) mem[count[AW-1:0]] <= bus.push_data;
  end
  always_comb begin
    full = count == CAP;
    top = count - 1'b1;
    push_ok = state == FILL && bus.push_valid && !full;
    pop = state == DRAIN && bus.out_ready;
    count_nx = push_ok ? count + 1'b1 : pop ? count - 1'b1 : count;
    dropped_nx = dropped | (bus.push_valid && (state == DRAIN || full));
    // a same-cycle accepted push makes an otherwise empty stack drainable
    state_nx = state == FILL ? ((bus.drain && (count != '0 || push_ok)) ? DRAIN : FILL)
             : ((pop && count == CW'(1)) ? FILL : DRAIN);
  end
  assign bus.out_valid = state == DRAIN;
  assign bus.out_data = mem[top[AW-1:0]];
  assign bus.out_last = state == DRAIN && count == CW'(1);
  assign bus.full = full;
  assign bus.empty = count == '0;
  assign bus.count = count;
  assign bus.dropped = dropped;
endmodule
